game_flow_controller: RTL and testbench

- Top-level game sequencer for the tank game.
- Drives the menu/play mode inputs of the pixel colour path: start_game, menu_num, menuboxY.
- Tracks per-round hits and scores, and freezes motion between rounds.
- Issues a one-cycle round_reset that re-spawns tanks, bullets and walls.
- Sits between the keyboard keycode register, the bullet/tank collision logic and the colour/motion blocks.

---
 rtl/game_flow_controller_pkg.sv | 39 +++
 rtl/game_flow_controller_if.sv | 28 ++
 rtl/game_flow_controller_edge_pulse.sv | 28 ++
 rtl/game_flow_controller.sv | 174 +++++++++++++++++
 tb/tb_game_flow_controller.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared types and constants for the tank game flow controller.
package game_flow_controller_pkg;

    typedef enum logic [1:0] {
        MENU       = 2'd0,
        PLAY       = 2'd1,
        ROUND_OVER = 2'd2,
        GAME_OVER  = 2'd3
    } game_state_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    localparam logic [1:0] MENU_OPT1 = 2'b01;
    localparam logic [1:0] MENU_OPT2 = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Score increment that sticks at the winning score instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

    // Winner code from the two scores; both at the limit is a draw.
    function automatic logic [1:0] winner_of(input logic [3:0] s1, input logic [3:0] s2,
                                             input logic [3:0] lim);
        if ((s1 >= lim) && (s2 >= lim)) return WIN_DRAW;
        if (s1 >= lim)                  return WIN_P1;
        if (s2 >= lim)                  return WIN_P2;
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game flow controller and the rest of the game.
interface game_flow_controller_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       tank1_hit;
    logic       tank2_hit;
    logic       start_game;
    logic [1:0] menu_num;
    logic [9:0] menuboxY;
    logic       freeze;
    logic       round_reset;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output frame_clk, keycode, tank1_hit, tank2_hit,
        input  start_game, menu_num, menuboxY, freeze, round_reset,
               score1, score2, game_over, winner
    );

    modport slave (
        input  frame_clk, keycode, tank1_hit, tank2_hit,
        output start_game, menu_num, menuboxY, freeze, round_reset,
               score1, score2, game_over, winner
    );
endinterface

// File: rtl/game_flow_controller_edge_pulse.sv
// Rising-edge detector with an optional 2-flop synchroniser in front.
module edge_pulse #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic sig,
    output logic pulse
);
    logic sync1, sync2, prev;
    logic level;

    assign level = SYNC_EN ? sync2 : sig;
    assign pulse = level & ~prev;

    // Synchroniser chain and previous-level register for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
            prev  <= level;
        end
    end
endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: menu selection, round scoring, inter-round hold and match end.
//
// state      | meaning
// MENU       | menu screen, W/S move the selection, ENTER starts a match
// PLAY       | arena live, first hit ends the round
// ROUND_OVER | motion frozen, holding ROUND_FRAMES frames before re-spawn
// GAME_OVER  | a player reached WIN_SCORE, ENTER returns to the menu
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter logic [3:0] WIN_SCORE    = 4'd5,
    parameter logic [7:0] ROUND_FRAMES = 8'd120,
    parameter logic [9:0] MENU_BOX_Y1  = 10'd240,
    parameter logic [9:0] MENU_BOX_Y2  = 10'd288
) (
    input  logic                   Clk,
    input  logic                   Reset,
    game_flow_controller_if.slave  bus
);
    game_state_t state, state_nxt;

    logic       start_game_q,  start_game_nxt;
    logic [1:0] menu_num_q,    menu_num_nxt;
    logic [9:0] menuboxY_q,    menuboxY_nxt;
    logic       freeze_q,      freeze_nxt;
    logic       round_reset_q, round_reset_nxt;
    logic [3:0] score1_q,      score1_nxt;
    logic [3:0] score2_q,      score2_nxt;
    logic       game_over_q,   game_over_nxt;
    logic [1:0] winner_q,      winner_nxt;
    logic [7:0] frame_cnt_q,   frame_cnt_nxt;
    logic [7:0] key_prev_q;

    logic frame_tick;
    logic key_press, key_w, key_s, key_enter, key_esc;
    logic any_hit, score_won, round_done, abort;

    edge_pulse #(.SYNC_EN(1'b1)) u_frame_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .sig   (bus.frame_clk),
        .pulse (frame_tick)
    );

    // A key counts once, on the transition out of "no key"; holding it does not repeat.
    assign key_press  = (key_prev_q == KEY_NONE) && (bus.keycode != KEY_NONE);
    assign key_w      = key_press && (bus.keycode == KEY_W);
    assign key_s      = key_press && (bus.keycode == KEY_S);
    assign key_enter  = key_press && (bus.keycode == KEY_ENTER);
    assign key_esc    = key_press && (bus.keycode == KEY_ESC);
    assign abort      = key_esc && (state != MENU);
    assign any_hit    = bus.tank1_hit | bus.tank2_hit;
    assign score_won  = (score1_q >= WIN_SCORE) || (score2_q >= WIN_SCORE);
    assign round_done = frame_tick && (frame_cnt_q == ROUND_FRAMES - 8'd1);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= MENU;
        else       state <= state_nxt;
    end

    // Next-state decode; ESC outranks every other event outside the menu.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = MENU;
        end else begin
            case (state)
                MENU:       if (key_enter) state_nxt = PLAY;
                PLAY:       if (any_hit)   state_nxt = ROUND_OVER;
                ROUND_OVER: begin
                    if (score_won)       state_nxt = GAME_OVER;
                    else if (round_done) state_nxt = PLAY;
                end
                GAME_OVER:  if (key_enter) state_nxt = MENU;
                default:    state_nxt = MENU;
            endcase
        end
    end

    // Next values of the registered outputs, scores and frame counter.
    always_comb begin
        menu_num_nxt    = menu_num_q;
        score1_nxt      = score1_q;
        score2_nxt      = score2_q;
        winner_nxt      = winner_q;
        frame_cnt_nxt   = frame_cnt_q;
        round_reset_nxt = 1'b0;
        if (abort) begin
            score1_nxt    = 4'd0;
            score2_nxt    = 4'd0;
            winner_nxt    = WIN_NONE;
            frame_cnt_nxt = 8'd0;
        end else begin
            case (state)
                MENU: begin
                    if (key_w) menu_num_nxt = MENU_OPT1;
                    if (key_s) menu_num_nxt = MENU_OPT2;
                    if (key_enter) begin
                        score1_nxt      = 4'd0;
                        score2_nxt      = 4'd0;
                        round_reset_nxt = 1'b1;
                    end
                end
                PLAY: begin
                    if (bus.tank2_hit) score1_nxt = sat_inc(score1_q, WIN_SCORE);
                    if (bus.tank1_hit) score2_nxt = sat_inc(score2_q, WIN_SCORE);
                    if (any_hit)       frame_cnt_nxt = 8'd0;
                end
                ROUND_OVER: begin
                    if (score_won) begin
                        winner_nxt = winner_of(score1_q, score2_q, WIN_SCORE);
                    end else if (round_done) begin
                        round_reset_nxt = 1'b1;
                        frame_cnt_nxt   = 8'd0;
                    end else if (frame_tick) begin
                        frame_cnt_nxt = frame_cnt_q + 8'd1;
                    end
                end
                GAME_OVER: begin
                    if (key_enter) begin
                        score1_nxt = 4'd0;
                        score2_nxt = 4'd0;
                        winner_nxt = WIN_NONE;
                    end
                end
                default: ;
            endcase
        end
        start_game_nxt = (state_nxt != MENU);
        freeze_nxt     = (state_nxt != PLAY);
        game_over_nxt  = (state_nxt == GAME_OVER);
        menuboxY_nxt   = (menu_num_nxt == MENU_OPT2) ? MENU_BOX_Y2 : MENU_BOX_Y1;
    end

    // Output and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            start_game_q  <= 1'b0;
            menu_num_q    <= MENU_OPT1;
            menuboxY_q    <= MENU_BOX_Y1;
            freeze_q      <= 1'b1;
            round_reset_q <= 1'b0;
            score1_q      <= 4'd0;
            score2_q      <= 4'd0;
            game_over_q   <= 1'b0;
            winner_q      <= WIN_NONE;
            frame_cnt_q   <= 8'd0;
            key_prev_q    <= KEY_NONE;
        end else begin
            start_game_q  <= start_game_nxt;
            menu_num_q    <= menu_num_nxt;
            menuboxY_q    <= menuboxY_nxt;
            freeze_q      <= freeze_nxt;
            round_reset_q <= round_reset_nxt;
            score1_q      <= score1_nxt;
            score2_q      <= score2_nxt;
            game_over_q   <= game_over_nxt;
            winner_q      <= winner_nxt;
            frame_cnt_q   <= frame_cnt_nxt;
            key_prev_q    <= bus.keycode;
        end
    end

    assign bus.start_game  = start_game_q;
    assign bus.menu_num    = menu_num_q;
    assign bus.menuboxY    = menuboxY_q;
    assign bus.freeze      = freeze_q;
    assign bus.round_reset = round_reset_q;
    assign bus.score1      = score1_q;
    assign bus.score2      = score2_q;
    assign bus.game_over   = game_over_q;
    assign bus.winner      = winner_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller against a behavioural game model.
module tb_game_flow_controller;
    localparam logic [7:0] K_W   = 8'h1A;
    localparam logic [7:0] K_S   = 8'h16;
    localparam logic [7:0] K_ENT = 8'h28;
    localparam logic [7:0] K_ESC = 8'h29;
    localparam int WIN  = 5;
    localparam int HOLD = 120;

    typedef struct packed {
        logic       start_game;
        logic [1:0] menu_num;
        logic [9:0] menuboxY;
        logic       freeze;
        logic       round_reset;
        logic [3:0] score1;
        logic [3:0] score2;
        logic       game_over;
        logic [1:0] winner;
    } snap_t;

    typedef enum int {G_MENU, G_PLAY, G_HOLD, G_DONE} mode_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    game_flow_controller_if bus();

    game_flow_controller #(
        .WIN_SCORE(4'd5), .ROUND_FRAMES(8'd120),
        .MENU_BOX_Y1(10'd240), .MENU_BOX_Y2(10'd288)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #10 Clk = ~Clk;

    snap_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Behavioural model of the game rules.
    mode_t mode;
    int sel, p1, p2, frames, win_code;
    bit rr;
    bit [7:0] kprev;
    bit fh1, fh2, fh3;

    function automatic snap_t reset_view();
        snap_t v;
        v = '0;
        v.menu_num = 2'b01;
        v.menuboxY = 10'd240;
        v.freeze   = 1'b1;
        return v;
    endfunction

    function automatic snap_t model_view();
        snap_t v;
        v.start_game  = (mode != G_MENU);
        v.menu_num    = (sel == 1) ? 2'b01 : 2'b10;
        v.menuboxY    = (sel == 1) ? 10'd240 : 10'd288;
        v.freeze      = (mode != G_PLAY);
        v.round_reset = rr;
        v.score1      = 4'(p1);
        v.score2      = 4'(p2);
        v.game_over   = (mode == G_DONE);
        v.winner      = (mode == G_DONE) ? 2'(win_code) : 2'b00;
        return v;
    endfunction

    task automatic model_reset();
        mode = G_MENU; sel = 1; p1 = 0; p2 = 0; frames = 0; win_code = 0;
        rr = 0; kprev = 8'h00; fh1 = 0; fh2 = 0; fh3 = 0;
    endtask

    task automatic model_step();
        bit tick, kp;
        logic [7:0] k;
        tick = fh2 && !fh3;
        fh3 = fh2; fh2 = fh1; fh1 = bus.frame_clk;
        k = bus.keycode;
        kp = (kprev == 8'h00) && (k != 8'h00);
        kprev = k;
        rr = 0;
        if (kp && k == K_ESC && mode != G_MENU) begin
            mode = G_MENU; p1 = 0; p2 = 0; win_code = 0; frames = 0;
        end else begin
            case (mode)
                G_MENU: if (kp) begin
                    if (k == K_W) sel = 1;
                    else if (k == K_S) sel = 2;
                    else if (k == K_ENT) begin
                        p1 = 0; p2 = 0; rr = 1; mode = G_PLAY;
                    end
                end
                G_PLAY: if (bus.tank1_hit || bus.tank2_hit) begin
                    if (bus.tank2_hit) p1 = (p1 < WIN) ? p1 + 1 : WIN;
                    if (bus.tank1_hit) p2 = (p2 < WIN) ? p2 + 1 : WIN;
                    frames = 0;
                    mode = G_HOLD;
                end
                G_HOLD: begin
                    if (p1 >= WIN || p2 >= WIN) begin
                        mode = G_DONE;
                        win_code = ((p1 >= WIN) ? 1 : 0) + ((p2 >= WIN) ? 2 : 0);
                    end else if (tick) begin
                        frames++;
                        if (frames == HOLD) begin
                            frames = 0; rr = 1; mode = G_PLAY;
                        end
                    end
                end
                G_DONE: if (kp && k == K_ENT) begin
                    mode = G_MENU; p1 = 0; p2 = 0; win_code = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string name, input snap_t a, input snap_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got sg=%0d mn=%b y=%0d fz=%0d rr=%0d s1=%0d s2=%0d go=%0d w=%b, expected sg=%0d mn=%b y=%0d fz=%0d rr=%0d s1=%0d s2=%0d go=%0d w=%b",
                     name, $time,
                     a.start_game, a.menu_num, a.menuboxY, a.freeze, a.round_reset,
                     a.score1, a.score2, a.game_over, a.winner,
                     e.start_game, e.menu_num, e.menuboxY, e.freeze, e.round_reset,
                     e.score1, e.score2, e.game_over, e.winner);
        end
    endtask

    function automatic snap_t dut_view();
        snap_t v;
        v.start_game  = bus.start_game;
        v.menu_num    = bus.menu_num;
        v.menuboxY    = bus.menuboxY;
        v.freeze      = bus.freeze;
        v.round_reset = bus.round_reset;
        v.score1      = bus.score1;
        v.score2      = bus.score2;
        v.game_over   = bus.game_over;
        v.winner      = bus.winner;
        return v;
    endfunction

    // Model advances on the same edge as the DUT and queues the expected outputs.
    always @(posedge Clk) begin
        if (Reset) model_reset();
        else begin
            model_step();
            exp_q.push_back(model_view());
        end
    end

    // Monitor: compare DUT outputs half a cycle after each edge.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) check("outputs", dut_view(), exp_q.pop_front());
    end

    // Frame sync source: one frame every 6 clocks.
    initial begin
        bus.frame_clk = 1'b0;
        forever begin
            repeat (3) @(negedge Clk);
            bus.frame_clk = ~bus.frame_clk;
        end
    end

    task automatic press(input logic [7:0] k, input int hold);
        @(negedge Clk) bus.keycode = k;
        repeat (hold) @(negedge Clk);
        bus.keycode = 8'h00;
    endtask

    task automatic hit(input bit t1, input bit t2);
        @(negedge Clk);
        bus.tank1_hit = t1;
        bus.tank2_hit = t2;
        @(negedge Clk);
        bus.tank1_hit = 1'b0;
        bus.tank2_hit = 1'b0;
    endtask

    initial begin
        int key_left;
        bit last_hit;
        int r;
        bus.keycode = 8'h00;
        bus.tank1_hit = 1'b0;
        bus.tank2_hit = 1'b0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset_values", dut_view(), reset_view());
        Reset = 1'b0;

        // Menu navigation, held key, ENTER into play.
        press(K_W, 1);
        press(K_S, 10);
        press(K_W, 1);
        repeat (2) @(negedge Clk);
        press(K_ENT, 1);
        repeat (5) @(negedge Clk);

        // One round: tank2 struck, hit during hold ignored, re-spawn after 120 frames.
        hit(1'b0, 1'b1);
        repeat (100) @(negedge Clk);
        hit(1'b1, 1'b0);
        repeat (700) @(negedge Clk);

        // Fresh match, four draw rounds to 4/4, then a fifth draw ends it.
        press(K_ESC, 1);
        repeat (3) @(negedge Clk);
        press(K_ENT, 1);
        repeat (4) begin
            repeat (5) @(negedge Clk);
            hit(1'b1, 1'b1);
            repeat (800) @(negedge Clk);
        end
        hit(1'b1, 1'b1);
        repeat (10) @(negedge Clk);
        press(K_ENT, 1);
        repeat (5) @(negedge Clk);

        // ESC together with a hit in PLAY.
        press(K_ENT, 1);
        repeat (5) @(negedge Clk);
        bus.keycode = K_ESC;
        bus.tank1_hit = 1'b1;
        @(negedge Clk);
        bus.keycode = 8'h00;
        bus.tank1_hit = 1'b0;
        repeat (5) @(negedge Clk);

        // Asynchronous reset in the middle of the inter-round hold.
        press(K_ENT, 1);
        repeat (3) @(negedge Clk);
        hit(1'b0, 1'b1);
        repeat (50) @(negedge Clk);
        #7 Reset = 1'b1;
        #1 check("async_reset", dut_view(), reset_view());
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (800) @(negedge Clk);

        // Randomised play.
        key_left = 0;
        last_hit = 0;
        repeat (20000) begin
            @(negedge Clk);
            r = int'($urandom_range(0, 999));
            bus.tank1_hit = 1'b0;
            bus.tank2_hit = 1'b0;
            if (!last_hit) begin
                if (r < 15) bus.tank1_hit = 1'b1;
                else if (r < 30) bus.tank2_hit = 1'b1;
                else if (r < 33) begin
                    bus.tank1_hit = 1'b1;
                    bus.tank2_hit = 1'b1;
                end
            end
            last_hit = bus.tank1_hit | bus.tank2_hit;
            if (key_left > 0) begin
                key_left--;
            end else if (bus.keycode != 8'h00) begin
                bus.keycode = 8'h00;
            end else if ($urandom_range(0, 119) == 0) begin
                r = int'($urandom_range(0, 39));
                if (r == 0)       bus.keycode = K_ESC;
                else if (r <= 12) bus.keycode = K_ENT;
                else if (r <= 20) bus.keycode = K_W;
                else if (r <= 28) bus.keycode = K_S;
                else              bus.keycode = 8'($urandom_range(1, 255));
                key_left = int'($urandom_range(0, 5));
            end
        end
        bus.keycode = 8'h00;
        bus.tank1_hit = 1'b0;
        bus.tank2_hit = 1'b0;
        repeat (5) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
